// File: rtl/pic_multi.sv
// pic_multi: parametrised vectored interrupt controller.
//
// N_IRQ request lines with per-channel mask and edge/level selection.
// INTR_O is raised to the bus master while an unmasked request is pending.
// An INTA_I pulse returns VEC_BASE+winner on DataBus and moves the winner into
// service. EOI_I retires it.
//
// Optional build macro: ROTATE_PRIO_EN
//   undefined : fixed priority, index 0 highest
//   defined   : rotating priority, the channel just serviced drops to lowest
//
// Reset is synchronous and active-high (RST_I).

module pic_multi #(
    parameter int               N_IRQ    = 8,
    parameter int               DATA_W   = 8,
    parameter logic [DATA_W-1:0] VEC_BASE = 8'h20,
    parameter logic [DATA_W-1:0] SPUR_VEC = 8'hFF
) (
    input  logic              CLK_I,
    input  logic              RST_I,
    input  logic [N_IRQ-1:0]  IR,
    input  logic              CFG_WE,
    input  logic              CFG_SEL,
    input  logic [N_IRQ-1:0]  CFG_DAT,
    input  logic              INTA_I,
    input  logic              EOI_I,
    output logic              INTR_O,
    output logic [DATA_W-1:0] DataBus,
    output logic [N_IRQ-1:0]  IRR_O,
    output logic [N_IRQ-1:0]  ISR_O
);

    localparam int IDXW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } picState_e;

    picState_e         r_state;
    logic [N_IRQ-1:0]  r_irQ;
    logic [N_IRQ-1:0]  r_irr;
    logic [N_IRQ-1:0]  r_isr;
    logic [N_IRQ-1:0]  r_mask;
    logic [N_IRQ-1:0]  r_edge;
    logic              r_intr;
    logic [DATA_W-1:0] r_dataBus;

    logic [N_IRQ-1:0]  w_req;
    logic              w_reqAny;
    logic [IDXW-1:0]   w_winIdx;
    logic [N_IRQ-1:0]  w_winOneHot;
    logic              w_ack;
    logic [N_IRQ-1:0]  w_ackClr;
    logic [N_IRQ-1:0]  w_rise;
    logic [DATA_W-1:0] w_vector;

`ifdef ROTATE_PRIO_EN
    logic [IDXW-1:0]   r_ptr;
    logic [IDXW-1:0]   r_svcIdx;
    logic [N_IRQ-1:0]  w_rot;
    logic [IDXW-1:0]   w_off;
    logic [IDXW:0]     w_sum;
`endif

    assign w_req    = r_irr & ~r_mask;
    assign w_reqAny = |w_req;
    assign w_rise   = IR & ~r_irQ;
    assign w_vector = VEC_BASE + DATA_W'(w_winIdx);

    assign INTR_O  = r_intr;
    assign DataBus = r_dataBus;
    assign IRR_O   = r_irr;
    assign ISR_O   = r_isr;

`ifdef ROTATE_PRIO_EN
    // Rotating search: rotate req so the pointer sits at bit 0, pick the lowest
    // set bit, then add the pointer back modulo N_IRQ to recover the channel.
    always_comb begin
        w_rot    = (w_req >> r_ptr) | (w_req << (IDXW'(N_IRQ) - r_ptr));
        w_off    = '0;
        w_sum    = '0;
        w_winIdx = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = IDXW'(i);
            end
        end
        w_sum = {1'b0, r_ptr} + {1'b0, w_off};
        if (w_sum >= (IDXW+1)'(N_IRQ)) begin
            w_winIdx = IDXW'(w_sum - (IDXW+1)'(N_IRQ));
        end else begin
            w_winIdx = IDXW'(w_sum);
        end
    end
`else
    // Fixed priority search: the lowest-numbered pending unmasked channel wins.
    always_comb begin
        w_winIdx = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (w_req[i]) begin
                w_winIdx = IDXW'(i);
            end
        end
    end
`endif

    // Decode the winner and work out which IRR bit an acknowledge retires;
    // level channels are never cleared here because they simply track the pin.
    always_comb begin
        w_winOneHot = N_IRQ'(1) << w_winIdx;
        w_ack       = (r_state == REQ) && INTA_I && w_reqAny;
        w_ackClr    = '0;
        if (w_ack) begin
            w_ackClr = w_winOneHot & r_edge;
        end
    end

    // Input sampling and configuration registers; a write lands on the next
    // edge so anything decided this cycle still sees the old MASK/EDGE.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_irQ  <= '0;
            r_mask <= '1;
            r_edge <= '1;
        end else begin
            r_irQ <= IR;
            if (CFG_WE) begin
                if (CFG_SEL) begin
                    r_edge <= CFG_DAT;
                end else begin
                    r_mask <= CFG_DAT;
                end
            end
        end
    end

    // Pending register: edge channels latch a rising edge and hold it until
    // acknowledged (a fresh edge in the ack cycle keeps the bit set); level
    // channels follow the sampled pin.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_irr <= '0;
        end else begin
            r_irr <= (r_edge & (w_rise | (r_irr & ~w_ackClr))) | (~r_edge & IR);
        end
    end

    // Handshake FSM with registered INTR_O, DataBus and ISR.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_state   <= IDLE;
            r_intr    <= 1'b0;
            r_dataBus <= '0;
            r_isr     <= '0;
`ifdef ROTATE_PRIO_EN
            r_ptr     <= '0;
            r_svcIdx  <= '0;
`endif
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (INTA_I) begin
                        r_dataBus <= SPUR_VEC;
                    end
                    if (w_reqAny) begin
                        r_state <= REQ;
                        r_intr  <= 1'b1;
                    end else begin
                        r_intr  <= 1'b0;
                    end
                end
                REQ: begin
                    if (!w_reqAny) begin
                        r_state <= IDLE;
                        r_intr  <= 1'b0;
                        if (INTA_I) begin
                            r_dataBus <= SPUR_VEC;
                        end
                    end else if (INTA_I) begin
                        r_state   <= SERVICE;
                        r_intr    <= 1'b0;
                        r_dataBus <= w_vector;
                        r_isr     <= w_winOneHot;
`ifdef ROTATE_PRIO_EN
                        r_svcIdx  <= w_winIdx;
`endif
                    end else begin
                        r_intr  <= 1'b1;
                    end
                end
                SERVICE: begin
                    r_intr <= 1'b0;
                    if (INTA_I) begin
                        r_dataBus <= SPUR_VEC;
                    end
                    if (EOI_I) begin
                        r_isr   <= '0;
                        r_state <= IDLE;
`ifdef ROTATE_PRIO_EN
                        if (r_svcIdx == IDXW'(N_IRQ - 1)) begin
                            r_ptr <= '0;
                        end else begin
                            r_ptr <= r_svcIdx + IDXW'(1);
                        end
`endif
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_intr  <= 1'b0;
                end
            endcase
        end
    end

endmodule
